// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_hazard_unit                                                 |
// | Purpose  : Forwarding-select and load-use hazard unit for the pipelined    |
// |            MIPS core. Keeps a shadow pipeline of in-flight destinations    |
// |            (stage 1 = EX .. stage DEPTH = WB) and derives the EX operand   |
// |            forwarding selects, the load-use stall and a stall counter.     |
// | Ports    : clk_i, rst_i          clock, synchronous active-high reset      |
// |            id_valid_i            ID holds a real instruction               |
// |            id_rs_i, id_rt_i      ID source register addresses              |
// |            id_rd_i               ID destination register address           |
// |            id_regwrite_i         ID instruction writes the register file   |
// |            id_memread_i          ID instruction is a load                  |
// |            flush_i               kill the ID instruction                   |
// |            stall_o               hold PC and IF/ID, bubble into EX         |
// |            ex_fwd_rs_o/_rt_o     EX operand source: 0 = regfile,           |
// |                                  d = result held in stage d+1              |
// |            stall_count_o         saturating count of stall cycles          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fwd_hazard_unit #(
   parameter  int AW       = 5,
   parameter  int DEPTH    = 3,
   parameter  int LOAD_LAT = 1,
   localparam int SEL_W    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [AW-1:0]    id_rs_i,
   input  logic [AW-1:0]    id_rt_i,
   input  logic [AW-1:0]    id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic [SEL_W-1:0] ex_fwd_rs_o,
   output logic [SEL_W-1:0] ex_fwd_rt_o,
   output logic [15:0]      stall_count_o
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Shadow pipeline entries, index 1 = EX.
   logic [DEPTH:1]    v;
   logic [DEPTH:1]    wr;
   logic [AW-1:0]     rd [1:DEPTH];
   // The load flag only matters while the load's data is not yet forwardable,
   // so it is carried through stages 1..LOAD_LAT only.
   logic [LOAD_LAT:1] ld;
   logic [AW-1:0]     ex_rs;
   logic [AW-1:0]     ex_rt;
   logic [15:0]       stall_count;

   logic [DEPTH:1]    live;
   logic              load_hit;
   logic              stall;
   logic              bubble;
   logic [SEL_W-1:0]  fwd_rs;
   logic [SEL_W-1:0]  fwd_rt;

   // A producer is live only if it really writes a non-zero register.
   for (genvar k = 1; k <= DEPTH; k++) begin : g_live
      assign live[k] = v[k] & wr[k] & (rd[k] != '0);
   end

   always_comb begin
      load_hit = 1'b0;
      for (int k = 1; k <= LOAD_LAT; k++) begin
         if (live[k] && ld[k] && ((rd[k] == id_rs_i) || (rd[k] == id_rt_i)))
            load_hit = 1'b1;
      end
      // Flush wins: a killed instruction never waits on a load.
      stall  = id_valid_i & ~flush_i & load_hit;
      bubble = stall | flush_i;
   end

   // Scan from the oldest forwardable stage to the youngest so the youngest
   // matching producer overwrites older ones.
   always_comb begin
      fwd_rs = '0;
      fwd_rt = '0;
      for (int d = DEPTH - 1; d >= 1; d--) begin
         if (live[d+1] && (rd[d+1] == ex_rs))
            fwd_rs = SEL_W'(d);
         if (live[d+1] && (rd[d+1] == ex_rt))
            fwd_rt = SEL_W'(d);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v           <= '0;
         wr          <= '0;
         ld          <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         stall_count <= '0;
         for (int k = 1; k <= DEPTH; k++)
            rd[k] <= '0;
      end else begin
         if (bubble) begin
            v[1]  <= 1'b0;
            wr[1] <= 1'b0;
            ld[1] <= 1'b0;
            rd[1] <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
         end else begin
            v[1]  <= id_valid_i;
            wr[1] <= id_regwrite_i & id_valid_i;
            ld[1] <= id_memread_i & id_valid_i;
            rd[1] <= id_rd_i;
            ex_rs <= id_rs_i;
            ex_rt <= id_rt_i;
         end
         // Older stages keep draining even while ID is held.
         for (int k = 2; k <= DEPTH; k++) begin
            v[k]  <= v[k-1];
            wr[k] <= wr[k-1];
            rd[k] <= rd[k-1];
         end
         for (int k = 2; k <= LOAD_LAT; k++)
            ld[k] <= ld[k-1];
         if (stall && (stall_count != CNT_MAX))
            stall_count <= stall_count + 16'd1;
      end
   end

   assign stall_o       = stall;
   assign ex_fwd_rs_o   = fwd_rs;
   assign ex_fwd_rt_o   = fwd_rt;
   assign stall_count_o = stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fwd_hazard_unit                                              |
// | Purpose  : Directed self-checking bench for fwd_hazard_unit. Three         |
// |            instances: DEPTH=3/LOAD_LAT=1, DEPTH=5/LOAD_LAT=2 and           |
// |            DEPTH=8/LOAD_LAT=7 (counter saturation).                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fwd_hazard_unit;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       wr;
      logic       mr;
      logic       flush;
   } id_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   id_t  id0 = '0;
   id_t  id1 = '0;
   id_t  id2 = '0;

   logic        stall0, stall1, stall2;
   logic [1:0]  frs0, frt0;
   logic [2:0]  frs1, frt1, frs2, frt2;
   logic [15:0] cnt0, cnt1, cnt2;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.AW(5), .DEPTH(3), .LOAD_LAT(1)) u0 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id0.valid), .id_rs_i(id0.rs),
      .id_rt_i(id0.rt), .id_rd_i(id0.rd), .id_regwrite_i(id0.wr),
      .id_memread_i(id0.mr), .flush_i(id0.flush), .stall_o(stall0),
      .ex_fwd_rs_o(frs0), .ex_fwd_rt_o(frt0), .stall_count_o(cnt0));

   fwd_hazard_unit #(.AW(5), .DEPTH(5), .LOAD_LAT(2)) u1 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id1.valid), .id_rs_i(id1.rs),
      .id_rt_i(id1.rt), .id_rd_i(id1.rd), .id_regwrite_i(id1.wr),
      .id_memread_i(id1.mr), .flush_i(id1.flush), .stall_o(stall1),
      .ex_fwd_rs_o(frs1), .ex_fwd_rt_o(frt1), .stall_count_o(cnt1));

   fwd_hazard_unit #(.AW(5), .DEPTH(8), .LOAD_LAT(7)) u2 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id2.valid), .id_rs_i(id2.rs),
      .id_rt_i(id2.rt), .id_rd_i(id2.rd), .id_regwrite_i(id2.wr),
      .id_memread_i(id2.mr), .flush_i(id2.flush), .stall_o(stall2),
      .ex_fwd_rs_o(frs2), .ex_fwd_rt_o(frt2), .stall_count_o(cnt2));

   function automatic id_t op(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic wr, input logic mr);
      op = '{valid: 1'b1, rs: rs, rt: rt, rd: rd, wr: wr, mr: mr, flush: 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset with a load on r5 at ID ----------------
      id0 = op(5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
      step();
      chk("rst_stall_during", 32'(stall0), 0);
      step();
      rst = 1'b0;
      id0 = '0;
      #1;
      chk("rst_stall", 32'(stall0), 0);
      chk("rst_fwd_rs", 32'(frs0), 0);
      chk("rst_fwd_rt", 32'(frt0), 0);
      chk("rst_cnt", 32'(cnt0), 0);
      // Reader of r5: must not stall, the load never entered.
      step(); id0 = op(5'd5, 5'd5, 5'd1, 1'b1, 1'b0); #1;
      chk("rst_empty_stall", 32'(stall0), 0);

      // ---------------- ALU chain ----------------
      step(); id0 = op(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); #1;    // add r3
      step(); id0 = op(5'd3, 5'd3, 5'd4, 1'b1, 1'b0); #1;    // sub r4,r3,r3
      chk("alu_nostall", 32'(stall0), 0);
      step(); id0 = op(5'd3, 5'd0, 5'd8, 1'b1, 1'b0); #1;    // reads r3
      chk("alu_fwd_rs_1", 32'(frs0), 1);
      chk("alu_fwd_rt_1", 32'(frt0), 1);

      // ---------------- youngest wins / r0 ----------------
      step(); id0 = op(5'd1, 5'd1, 5'd7, 1'b1, 1'b0); #1;    // write r7
      chk("alu_fwd_rs_2", 32'(frs0), 2);
      chk("alu_fwd_rt_r0", 32'(frt0), 0);
      step(); id0 = op(5'd0, 5'd0, 5'd7, 1'b1, 1'b0); #1;    // write r7 again
      step(); id0 = op(5'd7, 5'd7, 5'd0, 1'b1, 1'b0); #1;    // read r7, write r0
      step(); id0 = op(5'd0, 5'd7, 5'd1, 1'b1, 1'b0); #1;    // read r0, r7
      chk("young_rs", 32'(frs0), 1);
      chk("young_rt", 32'(frt0), 1);

      // ---------------- load-use ----------------
      step(); id0 = op(5'd1, 5'd1, 5'd2, 1'b1, 1'b1); #1;    // lw r2
      chk("r0_fwd_rs", 32'(frs0), 0);
      chk("r7_fwd_rt_2", 32'(frt0), 2);
      chk("lw_issue_nostall", 32'(stall0), 0);
      step(); id0 = op(5'd2, 5'd1, 5'd9, 1'b1, 1'b0); #1;    // add r9,r2,r1
      chk("lu_stall", 32'(stall0), 1);
      chk("lu_cnt_before", 32'(cnt0), 0);
      step(); #1;                                            // ID held
      chk("lu_stall_released", 32'(stall0), 0);
      chk("lu_cnt", 32'(cnt0), 1);
      chk("lu_bubble_fwd", 32'(frs0), 0);
      step(); id0 = '0; #1;
      chk("lu_fwd_rs", 32'(frs0), 2);
      chk("lu_fwd_rt", 32'(frt0), 0);

      // ---------------- flush with stall ----------------
      step(); id0 = op(5'd1, 5'd1, 5'd2, 1'b1, 1'b1); #1;    // lw r2
      step(); id0 = op(5'd2, 5'd2, 5'd9, 1'b1, 1'b0); id0.flush = 1'b1; #1;
      chk("flush_nostall", 32'(stall0), 0);
      step(); id0 = op(5'd2, 5'd2, 5'd0, 1'b0, 1'b0); #1;
      chk("flush_cnt", 32'(cnt0), 1);
      chk("flush_stall_after", 32'(stall0), 0);
      chk("flush_bubble_fwd", 32'(frs0), 0);

      // ---------------- reset mid-stall ----------------
      step(); id0 = op(5'd1, 5'd1, 5'd2, 1'b1, 1'b1); #1;
      step(); id0 = op(5'd2, 5'd1, 5'd9, 1'b1, 1'b0); #1;
      chk("mid_stall", 32'(stall0), 1);
      rst = 1'b1;
      step(); rst = 1'b0; #1;
      chk("mid_rst_stall", 32'(stall0), 0);
      chk("mid_rst_cnt", 32'(cnt0), 0);

      // ---------------- DEPTH=5, LOAD_LAT=2 ----------------
      step(); id0 = '0; id1 = op(5'd0, 5'd0, 5'd6, 1'b1, 1'b1); #1;  // lw r6
      step(); id1 = op(5'd1, 5'd1, 5'd11, 1'b1, 1'b0); #1;           // independent
      chk("d5_indep_nostall", 32'(stall1), 0);
      step(); id1 = op(5'd6, 5'd6, 5'd12, 1'b1, 1'b0); #1;           // reads r6
      chk("d5_stall", 32'(stall1), 1);
      step(); #1;
      chk("d5_stall_released", 32'(stall1), 0);
      chk("d5_cnt", 32'(cnt1), 1);
      step(); id1 = '0; #1;
      chk("d5_fwd_rs", 32'(frs1), 3);
      chk("d5_fwd_rt", 32'(frt1), 3);

      // ---------------- DEPTH=8, LOAD_LAT=7 saturation ----------------
      // A self-dependent load held at ID stalls 7 of every 8 cycles:
      // after N edges the count is N - ceil(N/8).
      step(); id2 = op(5'd6, 5'd6, 5'd6, 1'b1, 1'b1); #1;
      chk("sat_first_nostall", 32'(stall2), 0);
      for (int n = 1; n <= 80; n++) step();
      chk("sat_cnt_80", 32'(cnt2), 70);
      for (int n = 81; n <= 74897; n++) step();
      chk("sat_cnt_74897", 32'(cnt2), 65534);
      step();
      chk("sat_cnt_74898", 32'(cnt2), 65535);
      for (int n = 74899; n <= 75001; n++) step();
      chk("sat_stall_held", 32'(stall2), 1);
      step();
      chk("sat_cnt_hold", 32'(cnt2), 65535);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
